// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder around one full_adder_top cell; SERIAL_ADDER_OVF_EN adds the ovf port
module full_adder_top (
  input  logic in1,
  input  logic in2,
  input  logic carry,
  output logic output_sum,
  output logic output_carry
);
  assign output_sum   = in1 ^ in2 ^ carry;
  assign output_carry = (in1 & in2) | (carry & (in1 ^ in2));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry_ff;
  logic [CW-1:0]    cnt;
  logic             bit_sum;
  logic             bit_carry;
  logic             last_bit;

  full_adder_top u_core (
    .in1          (a_sh[0]),
    .in2          (b_sh[0]),
    .carry        (carry_ff),
    .output_sum   (bit_sum),
    .output_carry (bit_carry)
  );

  // Result fills from the MSB end so after WIDTH shifts bit 0 lands at res_sh[0].
  assign res_next = {bit_sum, res_sh[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            carry_ff <= cin;
            cnt      <= '0;
            state    <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          res_sh   <= res_next;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          carry_ff <= bit_carry;
          if (last_bit) begin
            sum   <= res_next;
            cout  <= bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf   <= carry_ff ^ bit_carry;
`endif
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles until done, bounded; returns the number of busy samples.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      if (busy) n++;
      @(negedge clk);
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL timeout: got no done expected done within 30 cycles");
    end
  endtask

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_add(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tc, input logic [7:0] es, input logic ec, input logic eo);
    int n;
    launch(ta, tb_, tc);
    wait_done(n);
    check({tag, "_lat"}, n, 8);
    check({tag, "_done"}, done, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unused");
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n;
    int bad;
    int pulses;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_add("t5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_add("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("tff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // 80+80, then 01+02 accepted in the DONE cycle with start held high through RUN.
    launch(8'h80, 8'h80, 1'b0);
    wait_done(n);
    check("t8080_sum", sum, 8'h00);
    check("t8080_cout", cout, 1);
`ifdef SERIAL_ADDER_OVF_EN
    check("t8080_ovf", ovf, 1);
`endif
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("b2b_busy", busy, 1);
      if (n == 4) begin
        check("b2b_hold_sum", sum, 8'h00);
        check("b2b_hold_cout", cout, 1);
      end
    end while (!done && n < 30);
    start = 1'b0;
    check("b2b_gap", n, 9);
    check("b2b_sum", sum, 8'h03);
    check("b2b_cout", cout, 0);
    @(negedge clk);
    check("b2b_idle", busy, 0);

    // Reset at the 4th RUN edge aborts the operation.
    launch(8'hAA, 8'h55, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_nodone", pulses, 0);

    run_add("t1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h30 || cout !== 1'b0) bad++;
    end
    check("idle_hold", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
